// File: rtl/bundle_threshold_ctrl_if.sv
// Handshake and data bundle between a bundling client and bundle_threshold_ctrl.
// The master drives the run request and the input stream; the slave is the bundler.
interface bundle_threshold_ctrl_if #(
    parameter int D  = 5,
    parameter int CW = 8
);
    logic              start;
    logic [7:0]        num_samples;
    logic [CW-1:0]     threshold;
    logic              in_valid;
    logic              in_ready;
    logic [D-1:0]      in_hv;
    logic              out_valid;
    logic              out_ready;
    logic [D-1:0]      out_hv;
    logic [D*CW-1:0]   acc_out;
    logic              busy;

    modport master (
        output start, num_samples, threshold, in_valid, in_hv, out_ready,
        input  in_ready, out_valid, out_hv, acc_out, busy
    );

    modport slave (
        input  start, num_samples, threshold, in_valid, in_hv, out_ready,
        output in_ready, out_valid, out_hv, acc_out, busy
    );
endinterface

// File: rtl/bundle_threshold_ctrl.sv
// Hypervector bundler: accumulates per-bit population counts over a run of
// input hypervectors, then thresholds the counters into a class hypervector.
module bundle_threshold_ctrl #(
    parameter int D  = 5,
    parameter int CW = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    bundle_threshold_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        THRESH = 2'd2,
        OUT    = 2'd3
    } state_t;

    state_t                 state_q;
    logic [7:0]             num_q;
    logic [CW-1:0]          thr_q;
    logic [7:0]             cnt_q;
    logic [D-1:0][CW-1:0]   acc_q;
    logic [D-1:0]           out_hv_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic                   busy_q;

    logic [D-1:0][CW-1:0]   acc_d;
    logic [D-1:0]           out_hv_d;
    logic [7:0]             cnt_d;
    logic                   last_d;
    logic                   fire_s;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic b);
        logic [CW-1:0] r;
        if (b && (v != {CW{1'b1}})) begin
            r = v + CW'(1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    assign fire_s = bus.in_valid & in_ready_q;

    // Candidate counter increments, sample count and threshold compare.
    always_comb begin
        acc_d    = acc_q;
        out_hv_d = {D{1'b0}};
        for (int i = 0; i < D; i++) begin
            acc_d[i]    = sat_inc(acc_q[i], bus.in_hv[i]);
            out_hv_d[i] = (acc_q[i] > thr_q);
        end
        cnt_d  = cnt_q + 8'd1;
        last_d = (cnt_d == num_q);
    end

    // Run control FSM with its registered handshake outputs and datapath state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            num_q       <= 8'd0;
            thr_q       <= {CW{1'b0}};
            cnt_q       <= 8'd0;
            acc_q       <= {(D*CW){1'b0}};
            out_hv_q    <= {D{1'b0}};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && (bus.num_samples != 8'd0)) begin
                        num_q      <= bus.num_samples;
                        thr_q      <= bus.threshold;
                        cnt_q      <= 8'd0;
                        acc_q      <= {(D*CW){1'b0}};
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ACCUM;
                    end else begin
                        state_q    <= IDLE;
                    end
                end
                ACCUM: begin
                    if (fire_s) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        if (last_d) begin
                            in_ready_q <= 1'b0;
                            state_q    <= THRESH;
                        end else begin
                            state_q    <= ACCUM;
                        end
                    end else begin
                        state_q <= ACCUM;
                    end
                end
                THRESH: begin
                    out_hv_q    <= out_hv_d;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        state_q     <= OUT;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_hv    = out_hv_q;
    assign bus.acc_out   = acc_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_bundle_threshold_ctrl.sv
// Directed bench for bundle_threshold_ctrl: a default-width instance plus a
// narrow-counter instance that can actually reach saturation.
module tb_bundle_threshold_ctrl;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    bundle_threshold_ctrl_if #(.D(5), .CW(8)) bus ();
    bundle_threshold_ctrl_if #(.D(5), .CW(3)) sbus ();

    bundle_threshold_ctrl #(.D(5), .CW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    bundle_threshold_ctrl #(.D(5), .CW(3)) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.acc_out !== 40'h0) begin errors++; $display("FAIL reset_acc got=%h exp=0", bus.acc_out); end
        checks++; if (bus.out_hv !== 5'b00000) begin errors++; $display("FAIL reset_out_hv got=%b exp=00000", bus.out_hv); end
        rst = 1'b0;
    endtask

    task automatic test_basic_backpressure();
        logic [4:0] vec [4];
        logic       stable;
        vec[0] = 5'b11111; vec[1] = 5'b01111; vec[2] = 5'b00111; vec[3] = 5'b00011;
        bus.start = 1'b1; bus.num_samples = 8'd4; bus.threshold = 8'd3;
        tick();
        bus.start = 1'b0; bus.num_samples = 8'd10; bus.threshold = 8'd0;
        checks++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_accum_entry got busy=%b in_ready=%b exp=1,1", bus.busy, bus.in_ready); end
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1; bus.in_hv = vec[k];
            tick();
        end
        bus.in_valid = 1'b0; bus.in_hv = 5'b11111;
        checks++; if (bus.acc_out !== 40'h0102030404) begin errors++; $display("FAIL basic_acc got=%h exp=0102030404", bus.acc_out); end
        checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_thresh got in_ready=%b out_valid=%b exp=0,0", bus.in_ready, bus.out_valid); end
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_hv !== 5'b00011) begin errors++; $display("FAIL basic_out_hv got=%b exp=00011", bus.out_hv); end
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.out_valid !== 1'b1 || bus.out_hv !== 5'b00011 || bus.acc_out !== 40'h0102030404) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL backpressure_hold got out_valid=%b out_hv=%b exp=1,00011", bus.out_valid, bus.out_hv); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_idle got busy=%b out_valid=%b exp=0,0", bus.busy, bus.out_valid); end
        tick();
        checks++; if (bus.acc_out !== 40'h0102030404) begin errors++; $display("FAIL basic_retain got=%h exp=0102030404", bus.acc_out); end
    endtask

    task automatic test_saturation();
        bus.start = 1'b1; bus.num_samples = 8'd255; bus.threshold = 8'd254;
        tick();
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.in_hv = 5'b11111;
        for (int k = 0; k < 255; k++) tick();
        bus.in_valid = 1'b0;
        tick();
        checks++; if (bus.acc_out !== 40'hFFFFFFFFFF) begin errors++; $display("FAIL sat_run1_acc got=%h exp=FFFFFFFFFF", bus.acc_out); end
        checks++; if (bus.out_hv !== 5'b11111 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL sat_run1_out got hv=%b v=%b exp=11111,1", bus.out_hv, bus.out_valid); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.start = 1'b1; bus.num_samples = 8'd200; bus.threshold = 8'd254;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.acc_out !== 40'h0) begin errors++; $display("FAIL sat_run2_clear got=%h exp=0", bus.acc_out); end
        bus.in_valid = 1'b1; bus.in_hv = 5'b11111;
        for (int k = 0; k < 200; k++) tick();
        bus.in_valid = 1'b0;
        tick();
        checks++; if (bus.acc_out !== 40'hC8C8C8C8C8) begin errors++; $display("FAIL sat_run2_acc got=%h exp=C8C8C8C8C8", bus.acc_out); end
        checks++; if (bus.out_hv !== 5'b00000 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL sat_run2_out got hv=%b v=%b exp=00000,1", bus.out_hv, bus.out_valid); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_saturation_narrow();
        sbus.start = 1'b1; sbus.num_samples = 8'd10; sbus.threshold = 3'd6;
        tick();
        sbus.start = 1'b0;
        sbus.in_valid = 1'b1; sbus.in_hv = 5'b11111;
        for (int k = 0; k < 10; k++) tick();
        sbus.in_valid = 1'b0;
        tick();
        checks++; if (sbus.acc_out !== 15'h7FFF) begin errors++; $display("FAIL narrow_sat_acc got=%h exp=7fff", sbus.acc_out); end
        checks++; if (sbus.out_hv !== 5'b11111) begin errors++; $display("FAIL narrow_sat_out got=%b exp=11111", sbus.out_hv); end
        sbus.out_ready = 1'b1;
        tick();
        sbus.out_ready = 1'b0;
    endtask

    task automatic test_gaps_ignored_start();
        logic       v  [6];
        logic [4:0] hv [6];
        logic       s  [6];
        v[0]=1'b1; hv[0]=5'b00001; s[0]=1'b0;
        v[1]=1'b0; hv[1]=5'b11111; s[1]=1'b1;
        v[2]=1'b0; hv[2]=5'b11111; s[2]=1'b0;
        v[3]=1'b1; hv[3]=5'b00010; s[3]=1'b0;
        v[4]=1'b0; hv[4]=5'b11111; s[4]=1'b1;
        v[5]=1'b1; hv[5]=5'b00100; s[5]=1'b0;
        bus.start = 1'b1; bus.num_samples = 8'd3; bus.threshold = 8'd0;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.in_valid = v[k]; bus.in_hv = hv[k];
            bus.start = s[k]; bus.num_samples = 8'd1; bus.threshold = 8'd7;
            tick();
            if (k == 4) begin
                checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL gaps_early_end got in_ready=%b exp=1", bus.in_ready); end
            end
        end
        bus.in_valid = 1'b0; bus.start = 1'b0;
        checks++; if (bus.acc_out !== 40'h0000010101) begin errors++; $display("FAIL gaps_acc got=%h exp=0000010101", bus.acc_out); end
        checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL gaps_thresh got in_ready=%b busy=%b exp=0,1", bus.in_ready, bus.busy); end
        tick();
        checks++; if (bus.out_hv !== 5'b00111 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL gaps_out got hv=%b v=%b exp=00111,1", bus.out_hv, bus.out_valid); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.start = 1'b1; bus.num_samples = 8'd0; bus.threshold = 8'd0;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL zero_start got busy=%b in_ready=%b exp=0,0", bus.busy, bus.in_ready); end
        checks++; if (bus.acc_out !== 40'h0000010101) begin errors++; $display("FAIL zero_start_acc got=%h exp=0000010101", bus.acc_out); end
    endtask

    task automatic test_midrun_reset();
        logic seen_valid;
        bus.start = 1'b1; bus.num_samples = 8'd4; bus.threshold = 8'd0;
        tick();
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.in_hv = 5'b11111;
        tick();
        tick();
        checks++; if (bus.acc_out !== 40'h0202020202) begin errors++; $display("FAIL midrun_pre_acc got=%h exp=0202020202", bus.acc_out); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrun_idle got busy=%b in_ready=%b out_valid=%b exp=0,0,0", bus.busy, bus.in_ready, bus.out_valid); end
        checks++; if (bus.acc_out !== 40'h0) begin errors++; $display("FAIL midrun_acc got=%h exp=0", bus.acc_out); end
        seen_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen_valid = 1'b1;
        end
        bus.in_valid = 1'b0;
        checks++; if (seen_valid !== 1'b0) begin errors++; $display("FAIL midrun_no_output got=1 exp=0"); end
        bus.start = 1'b1; bus.num_samples = 8'd2; bus.threshold = 8'd1;
        tick();
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.in_hv = 5'b00011;
        tick();
        bus.in_hv = 5'b00001;
        tick();
        bus.in_valid = 1'b0;
        tick();
        checks++; if (bus.acc_out !== 40'h0000000102) begin errors++; $display("FAIL fresh_acc got=%h exp=0000000102", bus.acc_out); end
        checks++; if (bus.out_hv !== 5'b00001 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL fresh_out got hv=%b v=%b exp=00001,1", bus.out_hv, bus.out_valid); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL fresh_idle got busy=%b exp=0", bus.busy); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.num_samples = 8'd0; bus.threshold = 8'd0;
        bus.in_valid = 1'b0; bus.in_hv = 5'b00000; bus.out_ready = 1'b0;
        sbus.start = 1'b0; sbus.num_samples = 8'd0; sbus.threshold = 3'd0;
        sbus.in_valid = 1'b0; sbus.in_hv = 5'b00000; sbus.out_ready = 1'b0;
        test_reset();
        test_basic_backpressure();
        test_saturation();
        test_saturation_narrow();
        test_gaps_ignored_start();
        test_midrun_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
